// File: rtl/reset_seq_pkg.sv
// Shared FSM state encoding and parameter defaults for reset_sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_DOMAINS    = 3;
  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_STAGGER_CYCLES = 4;
  localparam int CNT_W              = 8;

endpackage

// File: rtl/reset_sync.sv
// Two-stage reset synchronizer: data_q asserts as soon as set rises and
// deasserts on the second rising clk edge after set falls.
module reset_sync (
  input  logic clk,
  input  logic set,
  output logic data_q
);

  logic [1:0] r_stage;

  always_ff @(posedge clk or posedge set) begin
    if (set) r_stage <= 2'b11;
    else     r_stage <= {r_stage[0], 1'b0};
  end

  assign data_q = r_stage[1];

endmodule

// File: rtl/reset_sequencer.sv
// Staggered multi-domain reset release sequencer with optional software reset.
// Define RESET_SEQ_SOFT_RST_EN to honour soft_req; otherwise soft_req is ignored.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   soft_req,
  output logic                   soft_ack,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   seq_done
);

  localparam logic [CNT_W-1:0]       HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [NUM_DOMAINS-1:0] ALL_ON       = {NUM_DOMAINS{1'b1}};

  logic w_set;
  logic w_sync_rst;
  logic w_soft_take;

  seq_state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [NUM_DOMAINS-1:0] r_rst, w_rst_nxt, w_rst_shift;
  logic                   r_done, w_done_nxt;
  logic                   r_ack, w_ack_nxt;

  assign w_set = ~reset_n;

  reset_sync u_reset_sync (
    .clk    (clk),
    .set    (w_set),
    .data_q (w_sync_rst)
  );

`ifdef RESET_SEQ_SOFT_RST_EN
  assign w_soft_take = soft_req;
`else
  logic w_unused_soft;
  assign w_unused_soft = soft_req;
  assign w_soft_take   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_rst   <= ALL_ON;
      r_done  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst   <= w_rst_nxt;
      r_done  <= w_done_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Shifting a zero in from bit 0 releases the domains in ascending order.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rst_nxt   = r_rst;
    w_done_nxt  = r_done;
    w_ack_nxt   = 1'b0;
    w_rst_shift = r_rst << 1;

    if (w_sync_rst) begin
      w_state_nxt = HOLD;
      w_cnt_nxt   = '0;
      w_rst_nxt   = ALL_ON;
      w_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          w_rst_nxt  = ALL_ON;
          w_done_nxt = 1'b0;
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = RELEASE;
            w_cnt_nxt   = '0;
            w_rst_nxt   = ALL_ON << 1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (r_rst == '0) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else if (r_cnt == STAGGER_LAST) begin
            w_cnt_nxt = '0;
            w_rst_nxt = w_rst_shift;
            if (w_rst_shift == '0) w_state_nxt = DONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          w_cnt_nxt  = '0;
          w_rst_nxt  = '0;
          w_done_nxt = 1'b1;
          if (w_soft_take) begin
            w_state_nxt = HOLD;
            w_ack_nxt   = 1'b1;
            w_rst_nxt   = ALL_ON;
            w_done_nxt  = 1'b0;
          end
        end
        default: begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_rst_nxt   = ALL_ON;
          w_done_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign soft_ack = r_ack;
  assign rst_out  = r_rst;
  assign seq_done = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: power-on table, soft/mid-sequence/glitch
// corner cases, then random traffic against an edge-counting reference model.
module tb_reset_sequencer;

  localparam int N = 3;
  localparam int H = 16;
  localparam int S = 4;
  // Edges after reset_n release at which bit 0 clears, and at which DONE is entered.
  localparam int T_REL     = 2 + H;
  localparam int T_DONE_ST = T_REL + ((N > 1) ? (N - 1) * S : 1);

`ifdef RESET_SEQ_SOFT_RST_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         soft_req;
  logic         soft_ack;
  logic [N-1:0] rst_out;
  logic         seq_done;

  int nChecks = 0;
  int nFails  = 0;
  bit chkEn   = 1'b0;

  // Reference model: m_k counts rising edges seen with reset_n high since the
  // last reset; every expected output is a plain arithmetic function of it.
  int m_k   = 0;
  bit m_ack = 1'b0;

  typedef struct {
    int         edgeNum;
    logic       softReq;
    logic [2:0] expRst;
    logic       expDone;
  } vec_t;

  vec_t vecs[10];

  reset_sequencer #(
    .NUM_DOMAINS    (N),
    .HOLD_CYCLES    (H),
    .STAGGER_CYCLES (S)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .soft_req (soft_req),
    .soft_ack (soft_ack),
    .rst_out  (rst_out),
    .seq_done (seq_done)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_k   <= 0;
      m_ack <= 1'b0;
    end else if (SOFT_EN && soft_req && m_k >= T_DONE_ST) begin
      m_k   <= 2;
      m_ack <= 1'b1;
    end else begin
      m_ack <= 1'b0;
      if (m_k < 1000000) m_k <= m_k + 1;
    end
  end

  always @(negedge reset_n) begin
    m_k   <= 0;
    m_ack <= 1'b0;
  end

  function automatic logic [N-1:0] expRst(input int k);
    logic [N-1:0] ones;
    int           rel;
    ones = '1;
    if (k < T_REL) return ones;
    rel = (k - T_REL) / S + 1;
    if (rel > N) rel = N;
    return ones << rel;
  endfunction

  function automatic logic expDone(input int k);
    return k > T_DONE_ST;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic sr);
    @(negedge clk);
    #3;
    reset_n  = rn;
    soft_req = sr;
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("model rst_out",  8'(rst_out),  8'(expRst(m_k)));
      checkOutput("model seq_done", 8'(seq_done), 8'(expDone(m_k)));
      checkOutput("model soft_ack", 8'(soft_ack), 8'(m_ack));
    end
  end

  initial begin
    int  j;
    int  r;
    bit  seen;

    vecs[0] = '{edgeNum: 1,  softReq: 1'b0, expRst: 3'b111, expDone: 1'b0};
    vecs[1] = '{edgeNum: 2,  softReq: 1'b0, expRst: 3'b111, expDone: 1'b0};
    vecs[2] = '{edgeNum: 17, softReq: 1'b1, expRst: 3'b111, expDone: 1'b0};
    vecs[3] = '{edgeNum: 18, softReq: 1'b1, expRst: 3'b110, expDone: 1'b0};
    vecs[4] = '{edgeNum: 21, softReq: 1'b1, expRst: 3'b110, expDone: 1'b0};
    vecs[5] = '{edgeNum: 22, softReq: 1'b1, expRst: 3'b100, expDone: 1'b0};
    vecs[6] = '{edgeNum: 25, softReq: 1'b1, expRst: 3'b100, expDone: 1'b0};
    vecs[7] = '{edgeNum: 26, softReq: 1'b0, expRst: 3'b000, expDone: 1'b0};
    vecs[8] = '{edgeNum: 27, softReq: 1'b0, expRst: 3'b000, expDone: 1'b1};
    vecs[9] = '{edgeNum: 30, softReq: 1'b0, expRst: 3'b000, expDone: 1'b1};

    reset_n  = 1'b1;
    soft_req = 1'b0;
    #1 reset_n = 1'b0;
    #1 chkEn = 1'b1;
    #100;
    checkOutput("reset rst_out",  8'(rst_out),  8'h07);
    checkOutput("reset seq_done", 8'(seq_done), 8'h00);
    checkOutput("reset soft_ack", 8'(soft_ack), 8'h00);

    // Power-on release; soft_req held across RELEASE must not disturb timing.
    applyStimulus(1'b1, 1'b0);
    j = 0;
    for (int v = 0; v < 10; v++) begin
      while (j < vecs[v].edgeNum) begin
        @(negedge clk);
        j++;
      end
      #1;
      checkOutput($sformatf("poweron rst_out edge %0d", j), 8'(rst_out), 8'(vecs[v].expRst));
      checkOutput($sformatf("poweron seq_done edge %0d", j), 8'(seq_done), 8'(vecs[v].expDone));
      #2 soft_req = vecs[v].softReq;
    end

    // One-cycle soft request while in DONE.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("soft ack pulse",     8'(soft_ack), SOFT_EN ? 8'h01 : 8'h00);
    checkOutput("soft rst_out",       8'(rst_out),  SOFT_EN ? 8'h07 : 8'h00);
    checkOutput("soft seq_done",      8'(seq_done), SOFT_EN ? 8'h00 : 8'h01);
    @(negedge clk);
    #1 checkOutput("soft ack one cycle", 8'(soft_ack), 8'h00);
    for (int i = 1; i < 24; i++) @(negedge clk);
    #1 checkOutput("soft seq_done edge 24", 8'(seq_done), SOFT_EN ? 8'h00 : 8'h01);
    @(negedge clk);
    #1 checkOutput("soft seq_done edge 25", 8'(seq_done), 8'h01);

    // 5 ns glitch between edges, then resequence up to the 3'b110 step.
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("glitch rst_out",  8'(rst_out),  8'h07);
    checkOutput("glitch seq_done", 8'(seq_done), 8'h00);
    #4 reset_n = 1'b1;
    for (int i = 0; i < T_REL + 1; i++) @(negedge clk);
    #1 checkOutput("glitch resequence rst_out", 8'(rst_out), 8'h06);

    // Mid-sequence reset, then release with soft_req held high throughout.
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midseq rst_out",  8'(rst_out),  8'h07);
    checkOutput("midseq seq_done", 8'(seq_done), 8'h00);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    j    = 0;
    seen = 1'b0;
    while (!seen && j < 60) begin
      @(negedge clk);
      j++;
      #1 seen = SOFT_EN ? (soft_ack == 1'b1) : (seq_done == 1'b1);
    end
    checkOutput("held soft event seen", 8'(seen), 8'h01);
    checkOutput("held soft event edge", 8'(j),    8'(T_DONE_ST + 1));
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) @(negedge clk);

    // Random traffic: occasional resets and glitches, sparse soft requests.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      #3;
      r        = $urandom_range(0, 399);
      soft_req = ($urandom_range(0, 7) == 0);
      if (r < 2) begin
        reset_n = 1'b0;
        #5 reset_n = 1'b1;
      end else if (r < 4) begin
        reset_n = 1'b0;
      end else begin
        reset_n = 1'b1;
      end
    end
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    #1 chkEn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 3: number of sequenced reset outputs (1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: cycles all outputs stay asserted after the synchronized reset releases (1..255).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 4: cycles between consecutive domain releases (1..255).
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port soft_req, input, 1: level request for a software-initiated reset sequence.
REQ-007 SHALL have port soft_ack, output, 1: one-cycle pulse when soft_req is accepted.
REQ-008 SHALL have port rst_out, output, NUM_DOMAINS: active-high domain resets; bit 0 releases first.
REQ-009 SHALL have port seq_done, output, 1: high when all domains are released.

Function
REQ-010 SHALL synchronize reset_n through a 2-stage synchronizer: assertion asynchronous, deassertion after 2 clk rising edges.
REQ-011 SHALL implement FSM states HOLD, RELEASE, DONE.
REQ-012 HOLD: all rst_out=1, seq_done=0; 8-bit counter counts HOLD_CYCLES edges from synchronized-reset release, then -> RELEASE with rst_out[0]=0 on the same edge.
REQ-013 RELEASE: rst_out[i] SHALL clear exactly STAGGER_CYCLES edges after rst_out[i-1]; released bits stay 0.
REQ-014 When the last bit clears, FSM SHALL -> DONE on that edge; seq_done=1 from the next edge.
REQ-015 With NUM_DOMAINS=1, RELEASE SHALL last one cycle: rst_out[0] clears on HOLD exit, seq_done rises one edge later.
REQ-016 DONE: rst_out all 0, seq_done=1; state held until soft reset or reset_n.
REQ-017 soft_req SHALL be sampled only in DONE; when high: soft_ack=1 for one cycle, rst_out all 1 and seq_done=0 on that edge, FSM -> HOLD, counter cleared.
REQ-018 soft_req in HOLD or RELEASE SHALL be ignored (no ack, timing unchanged).
REQ-019 soft_req still high on the next DONE SHALL be accepted again (level, not edge).
REQ-020 Counters SHALL saturate-free reload per stage; no wrap-around affects sequence timing.

Reset
REQ-021 reset_n low SHALL asynchronously force rst_out all 1, seq_done=0, soft_ack=0, FSM=HOLD, counters 0, including mid-sequence and on glitches shorter than one clk period.
REQ-022 Every deassertion of reset_n SHALL restart the full sequence from REQ-010.

Configuration
REQ-023 Macro RESET_SEQ_SOFT_RST_EN defined: soft reset per REQ-017..019.
REQ-024 Macro undefined: soft_req ignored, soft_ack tied 0, ports retained.

Structure
REQ-025 Package reset_seq_pkg SHALL hold FSM state encoding (HOLD=2'd0, RELEASE=2'd1, DONE=2'd2) and parameter defaults.
REQ-026 Synchronizer SHALL be the existing reset_sync sub-module (ports clk, set, data_q); no other sub-modules.

Verification (NUM_DOMAINS=3, HOLD_CYCLES=16, STAGGER_CYCLES=4, 20 ns clk)
REQ-027 Power-on: reset_n low 100 ns then high -> rst_out=3'b111 for 2+16 edges, then 3'b110, +4 edges 3'b100, +4 edges 3'b000, seq_done=1 one edge later.
REQ-028 Mid-sequence: reset_n low while rst_out=3'b110 -> rst_out=3'b111 and seq_done=0 before next edge; full sequence repeats after release.
REQ-029 Soft reset: soft_req=1 for 1 cycle in DONE -> soft_ack one-cycle pulse, rst_out=3'b111, seq_done=1 again 16+8+1 edges later.
REQ-030 soft_req=1 held throughout RELEASE -> no soft_ack until DONE, release edges unchanged; accepted on first DONE cycle.
REQ-031 Glitch: 5 ns reset_n low pulse between edges -> rst_out=3'b111 immediately, full resequence.
REQ-032 RESET_SEQ_SOFT_RST_EN undefined: soft_req=1 in DONE -> soft_ack=0, rst_out stays 3'b000, seq_done stays 1.
